// File: rtl/fir_agc_ctrl.sv
// Automatic output-shift controller for the FIR/DAC path.
// Measures the windowed peak magnitude of the FIR output stream and steps
// the FIR wrapper shift up on clipping, or down after sustained low windows.
module fir_agc_ctrl #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned SCALER       = 12,
   parameter int unsigned WINDOW_LOG2  = 10,
   parameter int unsigned LOW_THRESH   = 32,
   parameter int unsigned HOLD_WINDOWS = 4
) (
   input  logic                   s00_axis_aclk,
   input  logic                   s00_axis_areset,
   input  logic                   enable,
   input  logic [3:0]             manual_shift,
   input  logic                   mon_tvalid,
   input  logic                   mon_tready,
   input  logic [DATA_WIDTH-1:0]  mon_tdata,
   output logic [3:0]             shift,
   output logic                   shift_update,
   output logic [DATA_WIDTH-1:0]  peak_out,
   output logic [WINDOW_LOG2:0]   clip_count,
   output logic                   busy
);

   localparam int unsigned CW    = WINDOW_LOG2 + 1;
   localparam int unsigned AMT_W = 8;
   localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] MAX_POS  = ~MOST_NEG;

   typedef enum logic [1:0] {IDLE, ACCUM, EVAL, APPLY} state_t;

   state_t                 state;
   logic [WINDOW_LOG2-1:0] cnt;
   logic [DATA_WIDTH-1:0]  run_peak;
   logic [CW-1:0]          run_clip;
   logic [3:0]             low_cnt;
   logic                   dir_up;
   logic                   dir_down;

   logic                   accept_c;
   logic                   last_c;
   logic [AMT_W-1:0]       sh_amt_c;
   logic [DATA_WIDTH-1:0]  mag_c;
   logic [DATA_WIDTH-1:0]  smag_c;
   logic [DATA_WIDTH-1:0]  speak_c;
   logic                   clip_c;

   // Saturating absolute value; the most-negative input maps to the max positive value
   always_comb begin
      mag_c = mon_tdata;
      if (mon_tdata[DATA_WIDTH-1]) begin
         if (mon_tdata == MOST_NEG) mag_c = MAX_POS;
         else                       mag_c = -mon_tdata;
      end
   end

   assign accept_c = mon_tvalid && mon_tready;
   assign last_c   = (cnt == {WINDOW_LOG2{1'b1}});
   assign sh_amt_c = AMT_W'(SCALER) + AMT_W'(shift);
   assign smag_c   = mag_c >> sh_amt_c;
   assign speak_c  = run_peak >> sh_amt_c;
   assign clip_c   = (smag_c > DATA_WIDTH'(127));

   // Window accumulation, evaluation and shift stepping
   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_areset) begin
         state        <= IDLE;
         shift        <= '0;
         shift_update <= 1'b0;
         peak_out     <= '0;
         clip_count   <= '0;
         busy         <= 1'b0;
         cnt          <= '0;
         run_peak     <= '0;
         run_clip     <= '0;
         low_cnt      <= '0;
         dir_up       <= 1'b0;
         dir_down     <= 1'b0;
      end else begin
         shift_update <= 1'b0;
         case (state)
            IDLE: begin
               shift <= manual_shift;
               if (enable) begin
                  state    <= ACCUM;
                  busy     <= 1'b1;
                  cnt      <= '0;
                  run_peak <= '0;
                  run_clip <= '0;
                  low_cnt  <= '0;
                  dir_up   <= 1'b0;
                  dir_down <= 1'b0;
               end
            end
            ACCUM: begin
               if (!enable) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (accept_c) begin
                  if (mag_c > run_peak) run_peak <= mag_c;
                  run_clip <= run_clip + CW'(clip_c);
                  cnt      <= cnt + WINDOW_LOG2'(1);
                  if (last_c) state <= EVAL;
               end
            end
            EVAL: begin
               peak_out <= run_peak;
               clip_count <= run_clip;
               dir_up   <= 1'b0;
               dir_down <= 1'b0;
               if (speak_c > DATA_WIDTH'(127)) begin
                  dir_up  <= 1'b1;
                  low_cnt <= '0;
               end else if (speak_c < DATA_WIDTH'(LOW_THRESH)) begin
                  if (low_cnt + 4'd1 >= 4'(HOLD_WINDOWS)) begin
                     dir_down <= 1'b1;
                     low_cnt  <= '0;
                  end else begin
                     low_cnt <= low_cnt + 4'd1;
                  end
               end else begin
                  low_cnt <= '0;
               end
               state <= APPLY;
            end
            APPLY: begin
               if (dir_up && (shift != 4'hF)) begin
                  shift        <= shift + 4'd1;
                  shift_update <= 1'b1;
               end else if (dir_down && (shift != 4'h0)) begin
                  shift        <= shift - 4'd1;
                  shift_update <= 1'b1;
               end
               cnt      <= '0;
               run_peak <= '0;
               run_clip <= '0;
               if (enable) begin
                  state <= ACCUM;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
